alarm_clock_entry_fsm: RTL and testbench
========================================

// Module: alarm_clock_entry_fsm
// PURPOSE
//   Control FSM for the alarm clock's keypad and button interface. Sequences digit
//   entry into the 4-digit key register and decides what the display mux shows
//   (current time, alarm time or the digits being entered). Issues single-cycle load
//   strobes that commit the entered digits to the alarm register or the time counter.
//   Sits between the keypad/buttons and the key register, alarm register, counter and
//   display mux inside alarm_clock_top.
// PARAMETERS
//   NO_KEY       4'd10  key code meaning no key is pressed; codes 0-9 are digits
//   TIMEOUT_SEC  10     one_second pulses of inactivity before entry is abandoned
//                       (only with ALARM_ENTRY_TIMEOUT_EN)
// PORTS
//   clock          in   1  system clock
//   reset          in   1  asynchronous, active-high reset
//   one_second     in   1  1-cycle tick from the timegen, 1 Hz (faster under fastwatch)
//   key            in   4  keypad code: 0-9 digit, NO_KEY idle, 11-15 illegal
//   time_button    in   1  level; commit entered digits as current time
//   alarm_button   in   1  level; commit as alarm, or hold to view alarm
//   shift          out  1  1-cycle strobe: shift key into the key register
//   load_new_a     out  1  1-cycle strobe: load the key register into the alarm register
//   load_new_c     out  1  1-cycle strobe: load the key register into the time counter
//   show_new_time  out  1  display mux selects the key register
//   show_a         out  1  display mux selects the alarm register
//   digit_cnt      out  3  digits entered so far, 0..4, saturating
// BEHAVIOUR
//   Reset: state SHOW_TIME; all strobes, show_* and digit_cnt = 0.
//   Outputs are registered and decoded from the next state (one cycle after the cause).
//   States and transitions (evaluated each clock; first match wins):
//     SHOW_TIME: alarm_button -> SHOW_ALARM; key 0-9 -> KEY_STORED; else stay.
//     KEY_STORED: shift=1 for exactly 1 cycle; digit_cnt += 1 (saturates at 4);
//       -> KEY_WAIT.
//     KEY_WAIT: key==NO_KEY -> KEY_ENTRY; else stay. A held key gives exactly one shift.
//     KEY_ENTRY: show_new_time=1.
//       alarm_button and digit_cnt==4 -> SET_ALARM.
//       time_button and digit_cnt==4 -> SET_TIME.
//       key 0-9 -> KEY_STORED; else stay.
//       If both buttons are high, alarm wins.
//       A button with digit_cnt<4 is ignored (stay in KEY_ENTRY).
//     SHOW_ALARM: show_a=1 while alarm_button is held; release -> SHOW_TIME.
//     SET_ALARM: load_new_a=1 for 1 cycle; digit_cnt <- 0 -> SHOW_TIME.
//     SET_TIME: load_new_c=1 for 1 cycle; digit_cnt <- 0 -> SHOW_TIME.
//   Illegal keys 11-15 are treated as NO_KEY everywhere.
//   A 5th and later digit still shifts (the key register keeps the last 4 digits);
//     digit_cnt stays at 4.
//   load_new_a and load_new_c are never high together; shift is never high in the
//     same cycle as a load strobe.
//   Reset mid-entry: immediate return to SHOW_TIME; a pending strobe is dropped.
//   No state accepts a button edge before the FSM returns to SHOW_TIME, so a held
//     button after a load never causes a second load.
// CONFIGURATION
//   ALARM_ENTRY_TIMEOUT_EN defined:
//     - An inactivity counter counts one_second ticks in KEY_WAIT and KEY_ENTRY.
//     - It clears on every KEY_STORED.
//     - When it reaches TIMEOUT_SEC, the FSM goes to SHOW_TIME, digit_cnt <- 0 and
//       no load occurs.
//   ALARM_ENTRY_TIMEOUT_EN undefined: no counter; entry waits indefinitely.
//     TIMEOUT_SEC is unused.
// STRUCTURE
//   alarm_clock_pkg holds:
//     - the state typedef (SHOW_TIME, KEY_STORED, KEY_WAIT, KEY_ENTRY, SHOW_ALARM,
//       SET_ALARM, SET_TIME), 3-bit encoding;
//     - the NO_KEY constant;
//     - the DIGITS=4 constant.
//   One sub-module, alarm_entry_timeout: the inactivity counter (clear, tick ->
//     expired). It is instantiated only under ALARM_ENTRY_TIMEOUT_EN.
// TESTING
//   1 Reset high then low -> SHOW_TIME, all outputs 0, digit_cnt=0.
//   2 Keys 1,2,3,4, each held 5 cycles then NO_KEY; then time_button ->
//     4 single shift pulses, digit_cnt 1..4, one load_new_c pulse, digit_cnt=0.
//   3 Keys 1,2,3,5 then alarm_button held 20 cycles -> exactly one load_new_a pulse
//     followed by SHOW_TIME, with show_a=0 after the load.
//   4 Keys 1,2 then time_button -> no load, show_new_time stays 1.
//     Add keys 3,4 -> load_new_c on the next press.
//   5 4 digits then time_button and alarm_button in the same cycle -> load_new_a only.
//     Also: alarm_button from SHOW_TIME -> show_a=1 while held, 0 one cycle after
//     release.
//   6 (ALARM_ENTRY_TIMEOUT_EN, TIMEOUT_SEC=3) Key 7 then 3 one_second ticks ->
//     SHOW_TIME, digit_cnt=0, no load. Also: reset asserted in KEY_STORED -> no shift
//     pulse after reset.

Source files
------------

// File: rtl/alarm_clock_pkg.sv
// Shared definitions for the alarm clock keypad/button entry control.
// Holds the entry FSM state encoding, keypad idle code and digit count.
// No ports; imported by alarm_clock_entry_fsm and alarm_entry_timeout.
package alarm_clock_pkg;

  typedef enum logic [2:0] {
    SHOW_TIME  = 3'd0,
    KEY_STORED = 3'd1,
    KEY_WAIT   = 3'd2,
    KEY_ENTRY  = 3'd3,
    SHOW_ALARM = 3'd4,
    SET_ALARM  = 3'd5,
    SET_TIME   = 3'd6
  } state_e;

  // Keypad code meaning "nothing pressed"; codes 0-9 are digits, 11-15 illegal.
  localparam logic [3:0] NO_KEY = 4'd10;

  // Number of digits held by the key register.
  localparam logic [2:0] DIGITS = 3'd4;

  // Default inactivity limit, in one_second ticks, for the optional entry timeout.
  localparam int unsigned TIMEOUT_SEC_DEFAULT = 10;

  // Only 0-9 are digits; NO_KEY and the illegal codes all read as "no key".
  function automatic logic is_digit(input logic [3:0] k);
    return (k < NO_KEY);
  endfunction

endpackage

// File: rtl/alarm_entry_timeout.sv
// Inactivity counter for abandoned keypad entry.
// Counts tick pulses since the last clear and saturates at LIMIT.
// Ports: clock, reset (async, active-high), clear, tick in; expired out
//   (high while the count equals LIMIT, combinational from the count register).
module alarm_entry_timeout #(
  parameter int unsigned LIMIT = 10
) (
  input  logic clock,
  input  logic reset,
  input  logic clear,
  input  logic tick,
  output logic expired
);

  localparam int unsigned W = (LIMIT < 2) ? 1 : $clog2(LIMIT + 1);
  localparam logic [W-1:0] LIMIT_W = W'(LIMIT);

  logic [W-1:0] cnt_q, cnt_d;

  // Clear has priority so a key stored on the same cycle as a tick restarts the window.
  always_comb begin
    cnt_d = cnt_q;
    if (clear) begin
      cnt_d = '0;
    end else if (tick && (cnt_q != LIMIT_W)) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign expired = (cnt_q == LIMIT_W);

endmodule

// File: rtl/alarm_clock_entry_fsm.sv
// Keypad/button entry control for the alarm clock: sequences digit entry into the
// key register, selects the display source and strobes alarm/time loads.
// Ports: clock, reset (async, active-high), one_second, key[3:0], time_button,
//   alarm_button in; shift, load_new_a, load_new_c, show_new_time, show_a,
//   digit_cnt[2:0] out. All outputs are registered, decoded from the next state.
// Optional: ALARM_ENTRY_TIMEOUT_EN adds a TIMEOUT_SEC inactivity abort of entry.
module alarm_clock_entry_fsm
  import alarm_clock_pkg::*;
`ifdef ALARM_ENTRY_TIMEOUT_EN
#(
  parameter int unsigned TIMEOUT_SEC = TIMEOUT_SEC_DEFAULT
)
`endif
(
  input  logic       clock,
  input  logic       reset,
  input  logic       one_second,
  input  logic [3:0] key,
  input  logic       time_button,
  input  logic       alarm_button,
  output logic       shift,
  output logic       load_new_a,
  output logic       load_new_c,
  output logic       show_new_time,
  output logic       show_a,
  output logic [2:0] digit_cnt
);

  state_e     state_q, state_d;
  logic [2:0] digit_cnt_q, digit_cnt_d;
  logic       alarm_lock_q, alarm_lock_d;
  logic       shift_q, shift_d;
  logic       load_new_a_q, load_new_a_d;
  logic       load_new_c_q, load_new_c_d;
  logic       show_new_time_q, show_new_time_d;
  logic       show_a_q, show_a_d;

  logic       key_is_digit;
  logic       entry_full;
  logic       timeout_expired;

  assign key_is_digit = is_digit(key);
  assign entry_full   = (digit_cnt_q == DIGITS);

`ifdef ALARM_ENTRY_TIMEOUT_EN
  logic entry_waiting;
  logic timeout_clear;

  assign entry_waiting = (state_q == KEY_WAIT) || (state_q == KEY_ENTRY);
  assign timeout_clear = (state_d == KEY_STORED);

  alarm_entry_timeout #(
    .LIMIT (TIMEOUT_SEC)
  ) u_timeout (
    .clock   (clock),
    .reset   (reset),
    .clear   (timeout_clear),
    .tick    (one_second && entry_waiting),
    .expired (timeout_expired)
  );
`else
  // Without the timeout, entry waits indefinitely and the tick has no consumer.
  logic unused_one_second;
  assign unused_one_second = one_second;
  assign timeout_expired   = 1'b0;
`endif

  // Next-state logic; the order of tests in each state is the priority order.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      SHOW_TIME: begin
        // The lock keeps an alarm button still held from a load from being
        // read as a request to view the alarm.
        if (alarm_button && !alarm_lock_q) begin
          state_d = SHOW_ALARM;
        end else if (key_is_digit) begin
          state_d = KEY_STORED;
        end
      end
      KEY_STORED: begin
        state_d = KEY_WAIT;
      end
      KEY_WAIT: begin
        if (timeout_expired) begin
          state_d = SHOW_TIME;
        end else if (!key_is_digit) begin
          state_d = KEY_ENTRY;
        end
      end
      KEY_ENTRY: begin
        if (timeout_expired) begin
          state_d = SHOW_TIME;
        end else if (alarm_button && entry_full) begin
          state_d = SET_ALARM;
        end else if (time_button && entry_full) begin
          state_d = SET_TIME;
        end else if (key_is_digit) begin
          state_d = KEY_STORED;
        end
      end
      SHOW_ALARM: begin
        if (!alarm_button) begin
          state_d = SHOW_TIME;
        end
      end
      SET_ALARM: begin
        state_d = SHOW_TIME;
      end
      SET_TIME: begin
        state_d = SHOW_TIME;
      end
      default: begin
        state_d = SHOW_TIME;
      end
    endcase
  end

  // Output and datapath decode from the next state, so every registered output
  // lines up with the state it belongs to.
  always_comb begin
    digit_cnt_d     = digit_cnt_q;
    alarm_lock_d    = alarm_lock_q;
    shift_d         = (state_d == KEY_STORED);
    load_new_a_d    = (state_d == SET_ALARM);
    load_new_c_d    = (state_d == SET_TIME);
    show_new_time_d = (state_d == KEY_ENTRY);
    show_a_d        = (state_d == SHOW_ALARM);

    // Digits past the fourth still shift, but the count saturates.
    if (state_d == KEY_STORED) begin
      if (digit_cnt_q != DIGITS) begin
        digit_cnt_d = digit_cnt_q + 3'd1;
      end
    end else if ((state_d == SET_ALARM) || (state_d == SET_TIME) ||
                 (state_d == SHOW_TIME)) begin
      // Covers loads and an abandoned (timed-out) entry alike.
      digit_cnt_d = 3'd0;
    end

    if (state_d == SET_ALARM) begin
      alarm_lock_d = 1'b1;
    end else if (!alarm_button) begin
      alarm_lock_d = 1'b0;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q         <= SHOW_TIME;
      digit_cnt_q     <= 3'd0;
      alarm_lock_q    <= 1'b0;
      shift_q         <= 1'b0;
      load_new_a_q    <= 1'b0;
      load_new_c_q    <= 1'b0;
      show_new_time_q <= 1'b0;
      show_a_q        <= 1'b0;
    end else begin
      state_q         <= state_d;
      digit_cnt_q     <= digit_cnt_d;
      alarm_lock_q    <= alarm_lock_d;
      shift_q         <= shift_d;
      load_new_a_q    <= load_new_a_d;
      load_new_c_q    <= load_new_c_d;
      show_new_time_q <= show_new_time_d;
      show_a_q        <= show_a_d;
    end
  end

  assign shift         = shift_q;
  assign load_new_a    = load_new_a_q;
  assign load_new_c    = load_new_c_q;
  assign show_new_time = show_new_time_q;
  assign show_a        = show_a_q;
  assign digit_cnt     = digit_cnt_q;

endmodule

// File: tb/tb_alarm_clock_entry_fsm.sv
module tb_alarm_clock_entry_fsm;
  import alarm_clock_pkg::*;

  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic       one_second = 1'b0;
  logic [3:0] key = NO_KEY;
  logic       time_button = 1'b0;
  logic       alarm_button = 1'b0;
  logic       shift, load_new_a, load_new_c, show_new_time, show_a;
  logic [2:0] digit_cnt;

  int vectors = 0;
  int miscompares = 0;
  int n_shift, n_la, n_lc, n_show_a, n_overlap;

  always #5 clock = ~clock;

`ifdef ALARM_ENTRY_TIMEOUT_EN
  alarm_clock_entry_fsm #(.TIMEOUT_SEC(3)) dut (
`else
  alarm_clock_entry_fsm dut (
`endif
    .clock         (clock),
    .reset         (reset),
    .one_second    (one_second),
    .key           (key),
    .time_button   (time_button),
    .alarm_button  (alarm_button),
    .shift         (shift),
    .load_new_a    (load_new_a),
    .load_new_c    (load_new_c),
    .show_new_time (show_new_time),
    .show_a        (show_a),
    .digit_cnt     (digit_cnt)
  );

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic clear_counts();
    n_shift = 0; n_la = 0; n_lc = 0; n_show_a = 0; n_overlap = 0;
  endtask

  // Advance n clocks, sampling 1 time unit after each rising edge.
  task automatic step(input int n = 1);
    for (int i = 0; i < n; i++) begin
      @(posedge clock);
      #1;
      n_shift  += int'(shift);
      n_la     += int'(load_new_a);
      n_lc     += int'(load_new_c);
      n_show_a += int'(show_a);
      if ((load_new_a && load_new_c) || (shift && (load_new_a || load_new_c)))
        n_overlap++;
    end
  endtask

  task automatic press_key(input logic [3:0] k, input int hold);
    key = k;
    step(hold);
    key = NO_KEY;
    step(2);
  endtask

  task automatic test_reset();
    reset = 1'b1;
    step(3);
    vectors++;
    if ({shift, load_new_a, load_new_c, show_new_time, show_a, digit_cnt} !== 8'h00) begin
      miscompares++;
      $display("FAIL reset_held: outputs=%b required 00000000",
               {shift, load_new_a, load_new_c, show_new_time, show_a, digit_cnt});
    end
    reset = 1'b0;
    clear_counts();
    step(3);
    vectors++;
    if ({shift, load_new_a, load_new_c, show_new_time, show_a, digit_cnt} !== 8'h00 ||
        n_shift != 0) begin
      miscompares++;
      $display("FAIL reset_released: outputs=%b shifts=%0d required 00000000 and 0",
               {shift, load_new_a, load_new_c, show_new_time, show_a, digit_cnt}, n_shift);
    end
  endtask

  task automatic test_set_time();
    logic [3:0] keys [4] = '{4'd1, 4'd2, 4'd3, 4'd4};
    clear_counts();
    for (int i = 0; i < 4; i++) begin
      press_key(keys[i], 5);
      vectors++;
      if (digit_cnt !== 3'(i + 1) || n_shift != i + 1 || show_new_time !== 1'b1) begin
        miscompares++;
        $display("FAIL set_time_digit%0d: cnt=%0d shifts=%0d show_new=%b required %0d %0d 1",
                 i, digit_cnt, n_shift, show_new_time, i + 1, i + 1);
      end
    end
    time_button = 1'b1;
    step(1);
    vectors++;
    if (load_new_c !== 1'b1 || load_new_a !== 1'b0 || digit_cnt !== 3'd0) begin
      miscompares++;
      $display("FAIL set_time_strobe: load_c=%b load_a=%b cnt=%0d required 1 0 0",
               load_new_c, load_new_a, digit_cnt);
    end
    step(3);
    time_button = 1'b0;
    step(2);
    vectors++;
    if (n_lc != 1 || n_la != 0 || n_shift != 4 || digit_cnt !== 3'd0 ||
        show_new_time !== 1'b0 || n_overlap != 0) begin
      miscompares++;
      $display("FAIL set_time_totals: lc=%0d la=%0d shifts=%0d cnt=%0d show_new=%b ovl=%0d required 1 0 4 0 0 0",
               n_lc, n_la, n_shift, digit_cnt, show_new_time, n_overlap);
    end
  endtask

  task automatic test_set_alarm_held();
    logic [3:0] keys [4] = '{4'd1, 4'd2, 4'd3, 4'd5};
    clear_counts();
    for (int i = 0; i < 4; i++) press_key(keys[i], 2);
    alarm_button = 1'b1;
    step(20);
    vectors++;
    if (n_la != 1 || n_lc != 0 || n_show_a != 0 || show_a !== 1'b0 ||
        show_new_time !== 1'b0 || digit_cnt !== 3'd0) begin
      miscompares++;
      $display("FAIL alarm_held: la=%0d lc=%0d show_a_cycles=%0d show_a=%b show_new=%b cnt=%0d required 1 0 0 0 0 0",
               n_la, n_lc, n_show_a, show_a, show_new_time, digit_cnt);
    end
    alarm_button = 1'b0;
    step(2);
  endtask

  task automatic test_early_button();
    clear_counts();
    press_key(4'd1, 2);
    press_key(4'd2, 2);
    time_button = 1'b1;
    step(5);
    vectors++;
    if (n_lc != 0 || show_new_time !== 1'b1 || digit_cnt !== 3'd2) begin
      miscompares++;
      $display("FAIL early_button: lc=%0d show_new=%b cnt=%0d required 0 1 2",
               n_lc, show_new_time, digit_cnt);
    end
    time_button = 1'b0;
    step(1);
    press_key(4'd3, 2);
    press_key(4'd4, 2);
    time_button = 1'b1;
    step(1);
    vectors++;
    if (load_new_c !== 1'b1 || n_lc != 1) begin
      miscompares++;
      $display("FAIL early_button_then_full: load_c=%b lc=%0d required 1 1", load_new_c, n_lc);
    end
    time_button = 1'b0;
    step(2);
  endtask

  task automatic test_both_buttons_and_view();
    clear_counts();
    press_key(4'd9, 1);
    press_key(4'd8, 1);
    press_key(4'd7, 1);
    press_key(4'd6, 1);
    // Fifth digit: shifts again but the count holds at 4.
    press_key(4'd0, 1);
    vectors++;
    if (n_shift != 5 || digit_cnt !== 3'd4) begin
      miscompares++;
      $display("FAIL fifth_digit: shifts=%0d cnt=%0d required 5 4", n_shift, digit_cnt);
    end
    // Illegal code behaves as no key.
    key = 4'd13;
    step(3);
    key = NO_KEY;
    vectors++;
    if (n_shift != 5 || show_new_time !== 1'b1) begin
      miscompares++;
      $display("FAIL illegal_key: shifts=%0d show_new=%b required 5 1", n_shift, show_new_time);
    end
    time_button = 1'b1;
    alarm_button = 1'b1;
    step(3);
    vectors++;
    if (n_la != 1 || n_lc != 0 || n_overlap != 0) begin
      miscompares++;
      $display("FAIL both_buttons: la=%0d lc=%0d ovl=%0d required 1 0 0", n_la, n_lc, n_overlap);
    end
    time_button = 1'b0;
    alarm_button = 1'b0;
    step(2);
    alarm_button = 1'b1;
    step(1);
    vectors++;
    if (show_a !== 1'b1 || n_la != 1) begin
      miscompares++;
      $display("FAIL view_alarm_press: show_a=%b la=%0d required 1 1", show_a, n_la);
    end
    step(4);
    vectors++;
    if (show_a !== 1'b1) begin
      miscompares++;
      $display("FAIL view_alarm_held: show_a=%b required 1", show_a);
    end
    alarm_button = 1'b0;
    step(1);
    vectors++;
    if (show_a !== 1'b0 || n_la != 1) begin
      miscompares++;
      $display("FAIL view_alarm_release: show_a=%b la=%0d required 0 1", show_a, n_la);
    end
  endtask

  task automatic test_reset_in_key_stored();
    clear_counts();
    key = 4'd9;
    step(1);
    vectors++;
    if (shift !== 1'b1) begin
      miscompares++;
      $display("FAIL reset_mid_entry_setup: shift=%b required 1", shift);
    end
    reset = 1'b1;
    #1;
    vectors++;
    if (shift !== 1'b0 || digit_cnt !== 3'd0) begin
      miscompares++;
      $display("FAIL reset_mid_entry_async: shift=%b cnt=%0d required 0 0", shift, digit_cnt);
    end
    key = NO_KEY;
    step(2);
    reset = 1'b0;
    clear_counts();
    step(4);
    vectors++;
    if (n_shift != 0 || digit_cnt !== 3'd0 || show_new_time !== 1'b0) begin
      miscompares++;
      $display("FAIL reset_mid_entry_after: shifts=%0d cnt=%0d show_new=%b required 0 0 0",
               n_shift, digit_cnt, show_new_time);
    end
  endtask

  task automatic test_timeout();
    clear_counts();
    press_key(4'd7, 2);
`ifdef ALARM_ENTRY_TIMEOUT_EN
    for (int t = 0; t < 3; t++) begin
      if (t == 2) begin
        vectors++;
        if (show_new_time !== 1'b1 || digit_cnt !== 3'd1) begin
          miscompares++;
          $display("FAIL timeout_early: show_new=%b cnt=%0d required 1 1", show_new_time, digit_cnt);
        end
      end
      one_second = 1'b1;
      step(1);
      one_second = 1'b0;
      step(2);
    end
    vectors++;
    if (show_new_time !== 1'b0 || digit_cnt !== 3'd0 || n_la != 0 || n_lc != 0) begin
      miscompares++;
      $display("FAIL timeout_expire: show_new=%b cnt=%0d la=%0d lc=%0d required 0 0 0 0",
               show_new_time, digit_cnt, n_la, n_lc);
    end
`else
    for (int t = 0; t < 12; t++) begin
      one_second = 1'b1;
      step(1);
      one_second = 1'b0;
      step(1);
    end
    vectors++;
    if (show_new_time !== 1'b1 || digit_cnt !== 3'd1) begin
      miscompares++;
      $display("FAIL no_timeout: show_new=%b cnt=%0d required 1 1", show_new_time, digit_cnt);
    end
    reset = 1'b1;
    step(1);
    reset = 1'b0;
    step(1);
`endif
  endtask

  initial begin
    test_reset();
    test_set_time();
    test_set_alarm_held();
    test_early_button();
    test_both_buttons_and_view();
    test_reset_in_key_stored();
    test_timeout();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
